// File: rtl/cla_seq_ctrl.sv
// Sequential W-bit adder built from a single N-bit carry-lookahead slice.
// One slice is processed per clock; the carry is chained through a register.
module cla_seq_ctrl #(
  parameter int unsigned N = 8,
  parameter int unsigned K = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           cin,
  output logic           busy,
  output logic           done,
  output logic [N*K-1:0] sum,
  output logic           cout,
  output logic [N*K:0]   final_sum
);

  localparam int unsigned W    = N * K;
  localparam int unsigned IdxW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  logic [31:0]     base;
  logic [N-1:0]    sa, sb, g, p, slice_sum;
  logic [N:0]      c;
  logic            prop;

  assign base = 32'(idx_q) * N;

  // The one shared N-bit carry-lookahead adder: each carry is a flat
  // sum-of-products over generate/propagate terms, not a ripple chain.
  always_comb begin
    sa   = a_q[base +: N];
    sb   = b_q[base +: N];
    g    = sa & sb;
    p    = sa ^ sb;
    c    = '0;
    prop = 1'b0;
    c[0] = carry_q;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i];
      prop   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prop & g[j]);
        prop   = prop & p[j];
      end
      c[i+1] = c[i+1] | (prop & carry_q);
    end
    slice_sum = p ^ c[N-1:0];
  end

  // Next-state logic: accept in idle, one slice per edge in run, abort wins in run.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          sum_d   = '0;
          cout_d  = 1'b0;
          idx_d   = '0;
          state_d = StIdle;
        end else begin
          sum_d[base +: N] = slice_sum;
          carry_d          = c[N];
          if (idx_q == IdxW'(K - 1)) begin
            cout_d  = c[N];
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign final_sum = {cout_q, sum_q};

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Self-checking bench for cla_seq_ctrl; reference result is plain (W+1)-bit arithmetic.
module tb_cla_seq_ctrl;

  localparam int unsigned N = 8;
  localparam int unsigned K = 4;
  localparam int unsigned W = N * K;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic [W:0]   final_sum;

  int vectors = 0;
  int miscompares = 0;

  cla_seq_ctrl #(.N(N), .K(K)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .final_sum (final_sum)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  // Launch one operation and watch done for a bounded window. Edges are counted
  // with the accepting edge as edge 1; input operands are scrambled after acceptance.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                        output int lat, output int ndone, output logic [W:0] res);
    a = oa; b = ob; cin = oc; start = 1'b1;
    tick;
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'b0;
    lat = 0; ndone = 0; res = '0;
    for (int e = 2; e <= int'(K) + 5; e++) begin
      tick;
      if (done === 1'b1) begin
        ndone++;
        if (lat == 0) begin
          lat = e;
          res = final_sum;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; abort = 1'b1; a = '1; b = '1; cin = 1'b1;
    tick;
    vectors++;
    if ({busy, done, final_sum} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b final_sum=%h, want all zero",
               busy, done, final_sum);
    end
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    tick;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_hold: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_all_ones_carry;
    int lat, nd;
    logic [W:0] res;
    run_op(32'hFFFF_FFFF, 32'h0, 1'b1, lat, nd, res);
    vectors++;
    if (lat != int'(K) + 1) begin
      miscompares++;
      $display("FAIL ones_latency: got %0d edges, want %0d", lat, K + 1);
    end
    vectors++;
    if (res !== 33'h1_0000_0000) begin
      miscompares++;
      $display("FAIL ones_result: got %h, want 100000000", res);
    end
    vectors++;
    if (nd != 1) begin
      miscompares++;
      $display("FAIL ones_done_count: got %0d, want 1", nd);
    end
  endtask

  task automatic test_carry_prop;
    int lat, nd;
    logic [W:0] res;
    run_op(32'h0000_00C8, 32'h0000_0064, 1'b0, lat, nd, res);
    vectors++;
    if (res !== 33'h0_0000_012C) begin
      miscompares++;
      $display("FAIL carry_prop_result: got %h, want 00000012c", res);
    end
    vectors++;
    if (sum[15:8] !== 8'h01) begin
      miscompares++;
      $display("FAIL carry_prop_slice1: got %h, want 01", sum[15:8]);
    end
  endtask

  // Idle with start low must hold the last result; abort in idle does nothing.
  task automatic test_idle_hold;
    logic [W:0] held;
    held = model(32'h0000_00C8, 32'h0000_0064, 1'b0);
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'b1;
      tick;
    end
    abort = 1'b0;
    vectors++;
    if (final_sum !== held || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold: got final_sum=%h busy=%b, want %h busy=0",
               final_sum, busy, held);
    end
  endtask

  task automatic test_ignored_start;
    logic [W-1:0] a1, b1;
    logic [W:0]   res;
    int           nd;
    a1 = W'($urandom); b1 = W'($urandom);
    a = a1; b = b1; cin = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    nd = 0; res = '0;
    for (int e = 2; e <= int'(K) + 5; e++) begin
      // Re-request at edge 3 (two edges after acceptance) and while in the done cycle.
      start = (e == 3) || (done === 1'b1);
      a = ~a1; b = ~b1; cin = 1'b0;
      tick;
      if (done === 1'b1) begin
        nd++;
        res = final_sum;
      end
    end
    start = 1'b0;
    vectors++;
    if (res !== model(a1, b1, 1'b1)) begin
      miscompares++;
      $display("FAIL ignored_start_result: got %h, want %h", res, model(a1, b1, 1'b1));
    end
    vectors++;
    if (nd != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignored_start_pulses: got %0d done pulses busy=%b, want 1 busy=0",
               nd, busy);
    end
  endtask

  task automatic test_abort;
    int lat, nd;
    logic [W:0] res;
    a = 32'h1234_5678; b = 32'h0FED_CBA9; cin = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || final_sum !== '0) begin
      miscompares++;
      $display("FAIL abort_state: got busy=%b done=%b final_sum=%h, want 0 0 0",
               busy, done, final_sum);
    end
    nd = 0;
    for (int i = 0; i < int'(K) + 2; i++) begin
      tick;
      if (done === 1'b1) nd++;
    end
    vectors++;
    if (nd != 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d pulses, want 0", nd);
    end
    run_op(32'h8000_0001, 32'h7FFF_FFFF, 1'b0, lat, nd, res);
    vectors++;
    if (res !== model(32'h8000_0001, 32'h7FFF_FFFF, 1'b0) || nd != 1) begin
      miscompares++;
      $display("FAIL abort_recover: got %h pulses=%0d, want %h pulses=1",
               res, nd, model(32'h8000_0001, 32'h7FFF_FFFF, 1'b0));
    end
  endtask

  task automatic test_mid_reset;
    int nd;
    a = 32'hDEAD_BEEF; b = 32'h0101_0101; cin = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    vectors++;
    if ({busy, done, final_sum} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_state: got busy=%b done=%b final_sum=%h, want all zero",
               busy, done, final_sum);
    end
    nd = 0;
    for (int i = 0; i < int'(K) + 2; i++) begin
      tick;
      if (done === 1'b1) nd++;
    end
    vectors++;
    if (nd != 0) begin
      miscompares++;
      $display("FAIL mid_reset_no_done: got %0d pulses, want 0", nd);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   res;
    int           lat, nd;
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (n % 7 == 0) rb = ~ra;
      run_op(ra, rb, rc, lat, nd, res);
      vectors++;
      if (res !== model(ra, rb, rc)) begin
        miscompares++;
        $display("FAIL random_result[%0d]: got %h, want %h (a=%h b=%h cin=%b)",
                 n, res, model(ra, rb, rc), ra, rb, rc);
      end
      vectors++;
      if (nd != 1 || lat != int'(K) + 1) begin
        miscompares++;
        $display("FAIL random_done[%0d]: got pulses=%0d latency=%0d, want 1 and %0d",
                 n, nd, lat, K + 1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_all_ones_carry;
    test_carry_prop;
    test_idle_hold;
    test_ignored_start;
    test_abort;
    test_mid_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
